// File: rtl/vedic_seq_mult_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vedic_seq_mult_ctrl: sequential Urdhva Tiryagbhyam multiply controller   |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module vedic_seq_mult_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic               CP,
  input  logic               R,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = $clog2(2 * K);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int DW = 2 * DIGIT;

  localparam logic [CW-1:0] C_LAST = CW'(2 * K - 2);
  localparam logic [CW-1:0] C_KM1  = CW'(K - 1);
  localparam logic [IW-1:0] I_KM1  = IW'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_width
      $error("vedic_seq_mult_ctrl: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    c_col;
  logic [IW-1:0]    i_idx;

  logic [DIGIT-1:0] a_dig [K];
  logic [DIGIT-1:0] b_dig [K];

  generate
    for (genvar k = 0; k < K; k++) begin : g_digits
      assign a_dig[k] = a_reg[k*DIGIT +: DIGIT];
      assign b_dig[k] = b_reg[k*DIGIT +: DIGIT];
    end
  endgenerate

  logic          accept;
  logic          last_step;
  logic [IW-1:0] j_idx;
  logic [IW-1:0] i_hi;
  logic [CW-1:0] c_nx;
  logic [IW-1:0] i_lo_nx;
  logic [DW-1:0] pp;
  logic [PW-1:0] pp_shifted;
  logic [PW-1:0] acc_next;

  assign accept    = (state == S_IDLE) && start;
  assign last_step = (c_col == C_LAST);
  assign j_idx     = IW'(c_col - CW'(i_idx));
  // Column c spans i = max(0, c-K+1) .. min(c, K-1).
  assign i_hi      = (c_col > C_KM1) ? I_KM1 : c_col[IW-1:0];
  assign c_nx      = c_col + CW'(1);
  assign i_lo_nx   = (c_nx > C_KM1) ? IW'(c_nx - C_KM1) : '0;

  assign pp         = DW'(a_dig[i_idx]) * DW'(b_dig[j_idx]);
  assign pp_shifted = PW'(pp) << (int'(c_col) * DIGIT);
  assign acc_next   = acc + pp_shifted;

  always_ff @(posedge CP or posedge R) begin
    if (R) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_MAC;
      S_MAC:   if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_MAC:   busy  = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Operand capture, crosswise accumulation and result register.
  always_ff @(posedge CP or posedge R) begin
    if (R) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      c_col   <= '0;
      i_idx   <= '0;
      product <= '0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      acc   <= '0;
      c_col <= '0;
      i_idx <= '0;
    end else if (state == S_MAC) begin
      acc <= acc_next;
      if (last_step) begin
        product <= acc_next;
      end else if (i_idx == i_hi) begin
        c_col <= c_nx;
        i_idx <= i_lo_nx;
      end else begin
        i_idx <= i_idx + IW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vedic_seq_mult_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_vedic_seq_mult_ctrl: directed bench for 8-bit and 16-bit controllers  |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module tb_vedic_seq_mult_ctrl;

  logic        CP = 1'b0;
  logic        R  = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        ready, busy, done;
  logic [15:0] product;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ready16, busy16, done16;
  logic [31:0] product16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CP = ~CP;

  vedic_seq_mult_ctrl #(.WIDTH(8), .DIGIT(4)) dut (
    .CP(CP), .R(R), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  vedic_seq_mult_ctrl #(.WIDTH(16), .DIGIT(4)) dut16 (
    .CP(CP), .R(R), .start(start16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .product(product16)
  );

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  // Presents operands with start for one edge; caller guarantees ready=1.
  task automatic launch(input logic [7:0] va, input logic [7:0] vb);
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic launch16(input logic [15:0] va, input logic [15:0] vb);
    a16 = va; b16 = vb; start16 = 1'b1;
    tick();
    start16 = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    while (!done16 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    R = 1'b1;
    tick();
    n_checks++;
    if ({ready, busy, done, product} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset8: rdy/busy/done/prod got %b%b%b %h want 100 0000", ready, busy, done, product);
    end
    n_checks++;
    if ({ready16, busy16, done16, product16} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset16: rdy/busy/done/prod got %b%b%b %h want 100 00000000", ready16, busy16, done16, product16);
    end
    R = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    launch(8'h0D, 8'h0B);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      n_checks++;
      if ({ready, busy, done} !== 3'b010) begin
        n_fail++;
        $display("FAIL basic_busy c%0d: rdy/busy/done got %b%b%b want 010", cyc, ready, busy, done);
      end
      tick();
    end
    n_checks++;
    if ({ready, busy, done} !== 3'b001 || product !== 16'h008F) begin
      n_fail++;
      $display("FAIL basic_done: rdy/busy/done %b%b%b prod %h want 001 008F", ready, busy, done, product);
    end
    tick();
    n_checks++;
    if ({ready, busy, done} !== 3'b100 || product !== 16'h008F) begin
      n_fail++;
      $display("FAIL basic_idle: rdy/busy/done %b%b%b prod %h want 100 008F", ready, busy, done, product);
    end
  endtask

  task automatic test_corners();
    int n;
    launch(8'hFF, 8'hFF);
    wait_done(n);
    n_checks++;
    if (n !== 4 || product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL ff_x_ff: wait %0d prod %h want 4 FE01", n, product);
    end
    tick();
    launch(8'h00, 8'hA5);
    wait_done(n);
    n_checks++;
    if (n !== 4 || product !== 16'h0000) begin
      n_fail++;
      $display("FAIL zero_x_a5: wait %0d prod %h want 4 0000", n, product);
    end
    tick();
    launch(8'h80, 8'hFF);
    wait_done(n);
    n_checks++;
    if (n !== 4 || product !== 16'h7F80) begin
      n_fail++;
      $display("FAIL 80_x_ff: wait %0d prod %h want 4 7F80", n, product);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    a = 8'h03; b = 8'h05; start = 1'b1;
    tick();
    a = 8'h80; b = 8'h02;
    wait_done(n);
    n_checks++;
    if (n !== 4 || product !== 16'h000F) begin
      n_fail++;
      $display("FAIL b2b_first: wait %0d prod %h want 4 000F", n, product);
    end
    tick();
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: ready got %b want 1", ready);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || product !== 16'h000F) begin
      n_fail++;
      $display("FAIL b2b_restart: busy %b prod %h want 1 000F", busy, product);
    end
    wait_done(n);
    n_checks++;
    if (n !== 4 || product !== 16'h0100) begin
      n_fail++;
      $display("FAIL b2b_second: wait %0d prod %h want 4 0100", n, product);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int n;
    int dones;
    launch(8'h0D, 8'h0B);
    tick();
    a = 8'h11; b = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    n_checks++;
    if (n !== 2 || product !== 16'h008F) begin
      n_fail++;
      $display("FAIL ignore_start: wait %0d prod %h want 2 008F", n, product);
    end
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0 || product !== 16'h008F) begin
      n_fail++;
      $display("FAIL ignore_extra_done: extra dones %0d prod %h want 0 008F", dones, product);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int dones;
    launch(8'h0D, 8'h0B);
    tick();
    tick();
    #2 R = 1'b1;
    #1;
    n_checks++;
    if ({ready, busy, done, product} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_mid: rdy/busy/done/prod %b%b%b %h want 100 0000", ready, busy, done, product);
    end
    tick();
    R = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0 || product !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_no_done: dones %0d prod %h want 0 0000", dones, product);
    end
    launch(8'h0D, 8'h0B);
    n_checks++;
    if (product !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_prod_hold: prod %h want 0000 during run", product);
    end
    wait_done(n);
    n_checks++;
    if (n !== 4 || product !== 16'h008F) begin
      n_fail++;
      $display("FAIL reset_recover: wait %0d prod %h want 4 008F", n, product);
    end
    tick();
  endtask

  task automatic test_wide();
    int n;
    logic [15:0] ra, rb;
    logic [31:0] expv;
    launch16(16'hFFFF, 16'hFFFF);
    wait_done16(n);
    n_checks++;
    if (n !== 16 || product16 !== 32'hFFFE0001) begin
      n_fail++;
      $display("FAIL wide_max: wait %0d prod %h want 16 FFFE0001", n, product16);
    end
    tick();
    for (int t = 0; t < 1000; t++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      expv = {16'h0, ra} * {16'h0, rb};
      launch16(ra, rb);
      wait_done16(n);
      n_checks++;
      if (n !== 16 || product16 !== expv) begin
        n_fail++;
        $display("FAIL wide_rand %0d: %h*%h wait %0d prod %h want 16 %h", t, ra, rb, n, product16, expv);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
